// File: rtl/rate_pacer.sv
// Multi-channel fractional-interval tick pacer. Each channel runs a countdown
// plus fractional accumulator and buffers ticks in a saturating backlog.
module rate_pacer_ch #(
  parameter int INT_W        = 16,
  parameter int FRAC_W       = 16,
  parameter int BL_W         = 4,
  parameter int DEFAULT_INT  = 4,
  parameter int DEFAULT_FRAC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [INT_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_frac,
  input  logic              en,
  input  logic              ready,
  input  logic              ovf_clr,
  output logic              tick_valid,
  output logic [BL_W-1:0]   pend,
  output logic              overflow
);
  logic [INT_W-1:0]  per_int;
  logic [FRAC_W-1:0] per_frac, frac_acc, sum;
  logic [INT_W:0]    cnt;
  logic              slot, carry, accept, full, drop;

  assign slot         = en && (cnt == '0);
  assign {carry, sum} = {1'b0, frac_acc} + {1'b0, per_frac};
  assign accept       = (pend != '0) && ready;
  assign full         = &pend;
  assign drop         = slot && !accept && full;
  assign tick_valid   = (pend != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_int  <= INT_W'(DEFAULT_INT);
      per_frac <= FRAC_W'(DEFAULT_FRAC);
    end else if (cfg_wr) begin
      per_int  <= (cfg_int == '0) ? INT_W'(1) : cfg_int;
      per_frac <= cfg_frac;
    end
  end

  // Interval is per_int + carry cycles; cnt reloads one short because the slot cycle counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      frac_acc <= '0;
    end else if (!en) begin
      cnt      <= '0;
      frac_acc <= '0;
    end else if (slot) begin
      frac_acc <= sum;
      cnt      <= {1'b0, per_int} + {{INT_W{1'b0}}, carry} - (INT_W+1)'(1);
    end else begin
      cnt      <= cnt - (INT_W+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             pend <= '0;
    else if (slot && !accept && !full)   pend <= pend + BL_W'(1);
    else if (!slot && accept)            pend <= pend - BL_W'(1);
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end
endmodule

module rate_pacer #(
  parameter int NUM_CH       = 4,
  parameter int INT_W        = 16,
  parameter int FRAC_W       = 16,
  parameter int BL_W         = 4,
  parameter int DEFAULT_INT  = 4,
  parameter int DEFAULT_FRAC = 0,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [INT_W-1:0]       cfg_int,
  input  logic [FRAC_W-1:0]      cfg_frac,
  input  logic [NUM_CH-1:0]      ch_en,
  output logic [NUM_CH-1:0]      tick_valid,
  input  logic [NUM_CH-1:0]      tick_ready,
  output logic [NUM_CH*BL_W-1:0] backlog,
  output logic [NUM_CH-1:0]      overflow,
  input  logic                   ovf_clr
);
  logic [NUM_CH-1:0][BL_W-1:0] pend;

  assign backlog = pend;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rate_pacer_ch #(
      .INT_W(INT_W), .FRAC_W(FRAC_W), .BL_W(BL_W),
      .DEFAULT_INT(DEFAULT_INT), .DEFAULT_FRAC(DEFAULT_FRAC)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .cfg_wr    (cfg_we && (cfg_ch == CH_W'(i))),
      .cfg_int   (cfg_int),
      .cfg_frac  (cfg_frac),
      .en        (ch_en[i]),
      .ready     (tick_ready[i]),
      .ovf_clr   (ovf_clr),
      .tick_valid(tick_valid[i]),
      .pend      (pend[i]),
      .overflow  (overflow[i])
    );
  end
endmodule
